// File: rtl/cpu_pkg.sv
// Shared decode types: ALU operations, immediate formats, RV32I opcodes and the
// decoded-control bundle carried by the decode output register.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [4:0] rd;
    alu_op_e    alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // alt is instr[30]; only register-register ops turn it into SUB.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
    case (f3)
      3'b000:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate from the instruction word.
// Latency: combinational. Backpressure: none.
// Flow: pure function of its inputs, no handshake.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with RAW scoreboard and one-entry output register.
// Latency: 1 cycle accept-to-id_valid; rf read data aligned with id_valid.
// Backpressure: if_ready drops on flush, full-and-stalled output, or pending source.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic [4:0]      read_reg1,
  output logic [4:0]      read_reg2,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd,
  output alu_op_e         id_alu_op,
  output logic            id_reg_write,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_illegal,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [6:0] opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opc    = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign funct7 = if_instr[31:25];

  ctrl_t           d_ctrl, ctrl_q;
  imm_fmt_e        d_fmt;
  logic [XLEN-1:0] d_imm, imm_q, pc_q;
  logic            use_rs1, use_rs2, f7_ok;
  logic [4:0]      rs1_q, rs2_q;

  always_comb begin
    d_ctrl        = '0;
    d_ctrl.alu_op = ALU_ADD;
    d_fmt         = IMM_NONE;
    use_rs1       = 1'b1;
    use_rs2       = 1'b0;
    f7_ok         = (funct7 == 7'h00) || (funct7 == 7'h20);
    case (opc)
      OPC_LUI: begin
        d_fmt = IMM_U; d_ctrl.reg_write = 1'b1; d_ctrl.alu_op = ALU_PASS_B; use_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        d_fmt = IMM_U; d_ctrl.reg_write = 1'b1; use_rs1 = 1'b0;
      end
      OPC_JAL: begin
        d_fmt = IMM_J; d_ctrl.reg_write = 1'b1; d_ctrl.jump = 1'b1; use_rs1 = 1'b0;
      end
      OPC_JALR: begin
        d_fmt = IMM_I; d_ctrl.reg_write = 1'b1; d_ctrl.jump = 1'b1;
      end
      OPC_BRANCH: begin
        d_fmt = IMM_B; d_ctrl.branch = 1'b1; use_rs2 = 1'b1;
        case (funct3[2:1])
          2'b10:   d_ctrl.alu_op = ALU_SLT;
          2'b11:   d_ctrl.alu_op = ALU_SLTU;
          default: d_ctrl.alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        d_fmt = IMM_I; d_ctrl.reg_write = 1'b1; d_ctrl.mem_read = 1'b1;
      end
      OPC_STORE: begin
        d_fmt = IMM_S; d_ctrl.mem_write = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        d_fmt = IMM_I; d_ctrl.reg_write = 1'b1;
        d_ctrl.alu_op = alu_from_f3(funct3, if_instr[30], 1'b0);
        if ((funct3 == 3'b001 || funct3 == 3'b101) && !f7_ok) d_ctrl.illegal = 1'b1;
      end
      OPC_OP: begin
        d_ctrl.reg_write = 1'b1; use_rs2 = 1'b1;
        d_ctrl.alu_op = alu_from_f3(funct3, if_instr[30], 1'b1);
        if (!f7_ok) d_ctrl.illegal = 1'b1;
      end
      OPC_FENCE: ;
      default: d_ctrl.illegal = 1'b1;
    endcase
    // Illegal instructions carry no side effects and no immediate.
    if (d_ctrl.illegal) begin
      d_ctrl.reg_write = 1'b0;
      d_ctrl.mem_read  = 1'b0;
      d_ctrl.mem_write = 1'b0;
      d_ctrl.alu_op    = ALU_ADD;
      d_fmt            = IMM_NONE;
    end
    if (rd == 5'd0) d_ctrl.reg_write = 1'b0;
    d_ctrl.rd = d_ctrl.reg_write ? rd : 5'd0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr[31:7]),
    .fmt   (d_fmt),
    .imm   (d_imm)
  );

  logic [NREG-1:0] sb_q, wb_mask, pend_eff, sb_set;
  logic            rs1_busy, rs2_busy, hazard, accept, handoff;

  // A writeback in this cycle lands in the rf on negedge, so it already unblocks.
  assign wb_mask  = wb_valid ? (ONE << wb_rd) : '0;
  assign pend_eff = sb_q & ~wb_mask;
  assign rs1_busy = (rs1 != 5'd0) &&
                    (pend_eff[rs1] || (id_valid && ctrl_q.reg_write && ctrl_q.rd == rs1));
  assign rs2_busy = (rs2 != 5'd0) &&
                    (pend_eff[rs2] || (id_valid && ctrl_q.reg_write && ctrl_q.rd == rs2));
  assign hazard   = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy);

  assign if_ready = !flush && (!id_valid || id_ready) && !hazard;
  assign accept   = if_valid && if_ready;
  assign handoff  = id_valid && id_ready;
  assign sb_set   = (handoff && ctrl_q.reg_write && ctrl_q.rd != 5'd0) ? (ONE << ctrl_q.rd) : '0;

  assign read_reg1 = (id_valid && !id_ready) ? rs1_q : rs1;
  assign read_reg2 = (id_valid && !id_ready) ? rs2_q : rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= ((sb_q & ~wb_mask) | sb_set) & ~ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      ctrl_q   <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      ctrl_q   <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else if (accept) begin
      id_valid <= 1'b1;
      ctrl_q   <= d_ctrl;
      imm_q    <= d_imm;
      pc_q     <= if_pc;
      rs1_q    <= rs1;
      rs2_q    <= rs2;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

  assign id_pc        = pc_q;
  assign id_imm       = imm_q;
  assign id_rd        = ctrl_q.rd;
  assign id_alu_op    = ctrl_q.alu_op;
  assign id_reg_write = ctrl_q.reg_write;
  assign id_mem_read  = ctrl_q.mem_read;
  assign id_mem_write = ctrl_q.mem_write;
  assign id_branch    = ctrl_q.branch;
  assign id_jump      = ctrl_q.jump;
  assign id_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against an instruction-level model.
module tb_decode_stage;
  import cpu_pkg::*;

  logic        clk, rst_n;
  logic        if_valid, if_ready, id_valid, id_ready, flush, wb_valid;
  logic [31:0] if_instr, if_pc, id_pc, id_imm;
  logic [4:0]  read_reg1, read_reg2, id_rd, wb_rd;
  alu_op_e     id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_imm(id_imm),
    .id_rd(id_rd), .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_illegal(id_illegal),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu;
    logic wr, mr, mw, br, jp, ill;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: what the output register should hold and which registers await writeback.
  logic        m_valid;
  exp_t        m;
  logic [31:0] m_pc, m_instr, m_pend;
  logic        exp_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    alu_op_e tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic f7ok;
    int hi;
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    e = '0;
    e.alu = ALU_ADD;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    f7ok = (f7 == 7'd0) || (f7 == 7'd32);
    case (opc)
      7'h37: begin e.wr = 1; e.alu = ALU_PASS_B; e.imm = ins & 32'hFFFFF000; end
      7'h17: begin e.wr = 1; e.imm = ins & 32'hFFFFF000; end
      7'h6F: begin
        e.wr = 1; e.jp = 1;
        hi = ins[31] ? -1048576 : 0;
        e.imm = hi + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      7'h67: begin e.wr = 1; e.jp = 1; e.imm = $signed(ins) >>> 20; end
      7'h63: begin
        e.br = 1;
        hi = ins[31] ? -4096 : 0;
        e.imm = hi + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (f3 == 4 || f3 == 5) e.alu = ALU_SLT;
        else if (f3 == 6 || f3 == 7) e.alu = ALU_SLTU;
        else e.alu = ALU_SUB;
      end
      7'h03: begin e.wr = 1; e.mr = 1; e.imm = $signed(ins) >>> 20; end
      7'h23: begin
        e.mw = 1;
        hi = $signed(ins) >>> 25;
        e.imm = hi * 32 + int'(ins[11:7]);
      end
      7'h13: begin
        if ((f3 == 1 || f3 == 5) && !f7ok) e.ill = 1;
        else begin
          e.wr = 1; e.imm = $signed(ins) >>> 20; e.alu = tab[f3];
          if (f3 == 5 && f7 == 7'd32) e.alu = ALU_SRA;
        end
      end
      7'h33: begin
        if (!f7ok) e.ill = 1;
        else begin
          e.wr = 1; e.alu = tab[f3];
          if (f3 == 0 && f7 == 7'd32) e.alu = ALU_SUB;
          if (f3 == 5 && f7 == 7'd32) e.alu = ALU_SRA;
        end
      end
      7'h0F: ;
      default: e.ill = 1;
    endcase
    if (ins[11:7] == 5'd0) e.wr = 0;
    e.rd = e.wr ? ins[11:7] : 5'd0;
    return e;
  endfunction

  function automatic logic busy(input logic [4:0] rs, input logic [31:0] pe);
    return (rs != 0) && (pe[rs] || (m_valid && m.wr && m.rd == rs));
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic idr, input logic fl, input logic wbv, input logic [4:0] wr);
    if_valid = v; if_instr = ins; if_pc = pc; id_ready = idr;
    flush = fl; wb_valid = wbv; wb_rd = wr;
  endtask

  task automatic sample();
    logic [6:0]  opc;
    logic [31:0] pe;
    logic        u1, u2;
    @(negedge clk);
    opc = if_instr[6:0];
    u1 = !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6F);
    u2 = (opc == 7'h33 || opc == 7'h63 || opc == 7'h23);
    pe = m_pend & ~(wb_valid ? (32'd1 << wb_rd) : 32'd0);
    exp_ready = !flush && (!m_valid || id_ready) &&
                !(u1 && busy(if_instr[19:15], pe)) && !(u2 && busy(if_instr[24:20], pe));
    chk("if_ready", {31'd0, if_ready}, {31'd0, exp_ready});
    chk("read_reg1", {27'd0, read_reg1},
        {27'd0, (m_valid && !id_ready) ? m_instr[19:15] : if_instr[19:15]});
    chk("read_reg2", {27'd0, read_reg2},
        {27'd0, (m_valid && !id_ready) ? m_instr[24:20] : if_instr[24:20]});
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("id_pc", id_pc, m_pc);
      chk("id_imm", id_imm, m.imm);
      chk("id_rd", {27'd0, id_rd}, {27'd0, m.rd});
      chk("id_alu_op", {28'd0, id_alu_op}, {28'd0, m.alu});
      chk("id_ctrl", {26'd0, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal},
          {26'd0, m.wr, m.mr, m.mw, m.br, m.jp, m.ill});
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (wb_valid) m_pend[wb_rd] = 1'b0;
    if (m_valid && id_ready && m.wr) m_pend[m.rd] = 1'b1;
    if (flush) m_valid = 1'b0;
    else if (if_valid && exp_ready) begin
      m_valid = 1'b1; m = ref_decode(if_instr); m_pc = if_pc; m_instr = if_instr;
    end else if (id_ready) m_valid = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opcs [11];
    int k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h7F};
    ins = $urandom;
    k = $urandom_range(0, 10);
    ins[6:0] = opcs[k];
    ins[11:7] = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    int r;
    m_valid = 0; m = '0; m_pc = 0; m_instr = 0; m_pend = 0; exp_ready = 0;
    rst_n = 0;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    #12;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_imm", id_imm, 32'd0);
    chk("rst_id_rd", {27'd0, id_rd}, 32'd0);
    chk("rst_ctrl", {26'd0, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    rst_n = 1;
    @(posedge clk); #1;

    drive(0, 32'h00108133, 32'h0, 0, 0, 0, 5'd0);
    sample();
    chk("idle_read_reg1", {27'd0, read_reg1}, 32'd1);
    advance();

    drive(1, 32'h00500093, 32'h100, 0, 0, 0, 5'd0);
    sample(); advance();
    drive(1, 32'h00108133, 32'h104, 1, 0, 0, 5'd0);
    sample();
    chk("addi_valid", {31'd0, id_valid}, 32'd1);
    chk("addi_rd", {27'd0, id_rd}, 32'd1);
    chk("addi_imm", id_imm, 32'd5);
    chk("addi_alu", {28'd0, id_alu_op}, {28'd0, ALU_ADD});
    chk("addi_wr", {31'd0, id_reg_write}, 32'd1);
    chk("raw_stall_held", {31'd0, if_ready}, 32'd0);
    advance();
    for (int i = 0; i < 2; i++) begin
      sample(); chk("raw_stall_pend", {31'd0, if_ready}, 32'd0); advance();
    end
    drive(1, 32'h00108133, 32'h104, 1, 0, 1, 5'd1);
    sample(); chk("wb_bypass_ready", {31'd0, if_ready}, 32'd1); advance();

    drive(1, 32'h005201B3, 32'h108, 1, 0, 0, 5'd0);
    sample(); chk("add_x2_rd", {27'd0, id_rd}, 32'd2); advance();
    drive(1, 32'h00000013, 32'h10C, 0, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("hold_rr1", {27'd0, read_reg1}, 32'd4);
      chk("hold_rr2", {27'd0, read_reg2}, 32'd5);
      chk("hold_rd", {27'd0, id_rd}, 32'd3);
      chk("hold_ready", {31'd0, if_ready}, 32'd0);
      advance();
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0);
    sample(); advance();

    drive(1, 32'h00100313, 32'h200, 1, 0, 0, 5'd0);
    sample(); advance();
    drive(1, 32'h00030393, 32'h204, 0, 1, 0, 5'd0);
    sample(); chk("flush_ready", {31'd0, if_ready}, 32'd0); advance();
    drive(1, 32'h00030393, 32'h204, 1, 0, 0, 5'd0);
    sample();
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_no_pend", {31'd0, if_ready}, 32'd1);
    advance();
    drive(1, 32'h0000FFFF, 32'h208, 1, 0, 0, 5'd0);
    sample(); advance();
    drive(1, 32'h00300393, 32'h20C, 1, 0, 0, 5'd0);
    sample();
    chk("illegal_flag", {31'd0, id_illegal}, 32'd1);
    chk("illegal_wr", {31'd0, id_reg_write}, 32'd0);
    chk("illegal_rd", {27'd0, id_rd}, 32'd0);
    advance();
    drive(1, 32'h00038413, 32'h210, 1, 0, 1, 5'd7);
    sample(); chk("set_wins_held", {31'd0, if_ready}, 32'd0); advance();
    drive(1, 32'h00038413, 32'h210, 1, 0, 0, 5'd7);
    sample(); chk("set_wins_pend", {31'd0, if_ready}, 32'd0); advance();
    drive(1, 32'h00038413, 32'h210, 1, 0, 1, 5'd7);
    sample(); chk("set_wins_wb", {31'd0, if_ready}, 32'd1); advance();

    for (int i = 0; i < 400; i++) begin
      ins = rand_instr();
      r = $urandom_range(1, 7);
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, m_pend[r] && ($urandom_range(0, 2) == 0), 5'(r));
      sample(); advance();
    end

    drive(1, 32'h00500093, 32'h300, 1, 0, 0, 5'd0);
    sample(); advance();
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
    m_valid = 0; m_pend = 0;
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    drive(1, 32'h00108133, 32'h304, 1, 0, 0, 5'd0);
    sample(); chk("async_rst_sb", {31'd0, if_ready}, 32'd1); advance();
    drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0);
    sample(); advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
